sync_updown_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 7 +
 rtl/t_ff_ar.sv | 11 +
 rtl/sync_updown_counter.sv | 44 ++++
 tb/tb_sync_updown_counter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the counter library
package counter_pkg;
    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
    function automatic int unsigned clamp_mod(input int unsigned v, input int unsigned m);
        return (v < m) ? v : m - 1;
    endfunction
endpackage

// File: rtl/t_ff_ar.sv
// t_ff_ar: toggle flip-flop with asynchronous active-low reset to 0
module t_ff_ar (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= 1'b0;
        else      q <= q ^ t;
endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: synchronous modulo-MOD up/down counter with load, enable and registered tc
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MOD   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             zero
);
    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MOD - 1);
    cnt_dir_e         dir;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] t;
    logic             wrap;
    assign dir  = cnt_dir_e'(up_dn);
    assign zero = (out == '0);
    always_comb begin
        ext  = {1'b0, out};
        wrap = en && !load && ((dir == CNT_UP) ? (ext == MAX) : (ext == '0));
        nxt  = load ? WIDTH'(clamp_mod(32'(load_val), MOD)) :
               !en  ? out :
               wrap ? ((dir == CNT_UP) ? '0 : WIDTH'(MAX)) :
               (dir == CNT_UP) ? WIDTH'(ext + 1'b1) : WIDTH'(ext - 1'b1);
        t    = nxt ^ out;
    end
    // Each bit toggles exactly when the computed next value differs from it
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_ar u_tff (.clk(clk), .rst(rst), .t(t[i]), .q(out[i]));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) tc <= 1'b0;
        else      tc <= wrap;
    always_ff @(posedge clk)
        if (rst) assert (!$isunknown({en, load, up_dn})) else $error("X on control input");
endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter: directed and random checks of sync_updown_counter at WIDTH=3, MOD=6
module tb_sync_updown_counter;
    logic       clk = 1'b0;
    logic       rst, en, up_dn, load;
    logic [2:0] load_val;
    logic [2:0] out;
    logic       tc, zero;
    int         total = 0;
    int         bad = 0;
    int         m, tcm;

    sync_updown_counter #(.WIDTH(3), .MOD(6)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .out(out), .tc(tc), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; en = 1'b0; load_val = 3'(v);
        step();
        load = 1'b0;
    endtask

    initial begin
        int up_out[7] = '{1, 2, 3, 4, 5, 0, 1};
        int up_tc[7]  = '{0, 0, 0, 0, 0, 1, 0};
        int dn_out[3] = '{5, 4, 3};
        int dn_tc[3]  = '{1, 0, 0};
        int fl_out[4] = '{5, 4, 5, 4};
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        #12;
        chk("reset_out", out, 0);
        chk("reset_tc", tc, 0);
        chk("reset_zero", zero, 1);
        @(negedge clk) rst = 1'b1;
        #4;
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("up_out%0d", i), out, up_out[i]);
            chk($sformatf("up_tc%0d", i), tc, up_tc[i]);
            chk($sformatf("up_zero%0d", i), zero, up_out[i] == 0);
        end
        do_load(0);
        chk("ld0_out", out, 0);
        en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("dn_out%0d", i), out, dn_out[i]);
            chk($sformatf("dn_tc%0d", i), tc, dn_tc[i]);
        end
        do_load(7);
        chk("clamp_out", out, 5);
        chk("clamp_tc", tc, 0);
        do_load(3);
        chk("ld3_out", out, 3);
        do_load(5);
        load = 1'b1; load_val = 3'd2; en = 1'b1; up_dn = 1'b1;
        step();
        chk("prio_out", out, 2);
        chk("prio_tc", tc, 0);
        load = 1'b0; en = 1'b0;
        step();
        chk("hold_out", out, 2);
        chk("hold_tc", tc, 0);
        do_load(4);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = (i % 2 == 0);
            step();
            chk($sformatf("flip_out%0d", i), out, fl_out[i]);
            chk($sformatf("flip_tc%0d", i), tc, 0);
        end
        do_load(5);
        en = 1'b1; up_dn = 1'b1;
        step();
        chk("pre_rst_tc", tc, 1);
        do_load(5);
        en = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out", out, 0);
        chk("async_rst_tc", tc, 0);
        step();
        step();
        chk("held_rst_out", out, 0);
        chk("held_rst_tc", tc, 0);
        #2 rst = 1'b1;
        step();
        chk("post_rst_out", out, 1);
        m = 1;
        for (int i = 0; i < 2000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            en = $urandom_range(0, 1);
            up_dn = $urandom_range(0, 1);
            load_val = 3'($urandom_range(0, 7));
            if (load) begin
                m = (load_val < 6) ? int'(load_val) : 5;
                tcm = 0;
            end else if (en && up_dn) begin
                tcm = (m == 5);
                m = (m + 1) % 6;
            end else if (en) begin
                tcm = (m == 0);
                m = (m + 5) % 6;
            end else tcm = 0;
            step();
            chk("rnd_out", out, m);
            chk("rnd_tc", tc, tcm);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
